trig_frame_gate: RTL and testbench

//  Consumes the trigger output of the signal-trigger stage and aligns it to video frame

---
 rtl/trig_frame_gate.sv | 144 ++++++++++++++
 tb/tb_trig_frame_gate.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_frame_gate.sv
// rtl/trig_frame_gate.sv - aligns trigger edges to whole-frame capture windows on vsync
module trig_frame_gate #(
  parameter int NUM_FRAMES  = 2,
  parameter int HOLDOFF_CYC = 1024,
  parameter bit VS_POL      = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             trig_in,
  input  logic             vsync_in,
  output logic             capture_en,
  output logic             capture_start,
  output logic             busy,
  output logic [7:0]       frame_idx,
  output logic             trig_missed,
  output logic [CNT_W-1:0] missed_cnt
);

  localparam int HW = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = (HOLDOFF_CYC > 0) ? HW'(HOLDOFF_CYC - 1) : '0;
  localparam logic [7:0] LAST_IDX = 8'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, HOLDOFF} state_t;

  state_t           state_q, state_d;
  logic             trig_q, trig_d;
  logic             vs_q, vs_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             capture_en_q, capture_en_d;
  logic             capture_start_q, capture_start_d;
  logic             busy_q, busy_d;
  logic [7:0]       frame_idx_q, frame_idx_d;
  logic             trig_missed_q, trig_missed_d;
  logic [CNT_W-1:0] missed_cnt_q, missed_cnt_d;

  logic trig_rise;
  logic vs_start;

  assign trig_rise = trig_in & ~trig_q;
  assign vs_start  = (vsync_in == VS_POL) & (vs_q != VS_POL);

  always_comb begin
    state_d         = state_q;
    trig_d          = trig_in;
    vs_d            = vsync_in;
    hold_d          = hold_q;
    capture_en_d    = capture_en_q;
    capture_start_d = 1'b0;
    frame_idx_d     = frame_idx_q;
    trig_missed_d   = 1'b0;
    missed_cnt_d    = missed_cnt_q;

    // Any trigger edge arriving while a run is in flight is rejected and counted.
    if (trig_rise && (state_q != IDLE)) begin
      trig_missed_d = 1'b1;
      if (~&missed_cnt_q) begin
        missed_cnt_d = missed_cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (trig_rise && enable) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        // Disarming wins over a coincident vsync so a disabled gate never opens.
        if (!enable) begin
          state_d = IDLE;
        end else if (vs_start) begin
          state_d         = CAPTURE;
          capture_en_d    = 1'b1;
          capture_start_d = 1'b1;
          frame_idx_d     = 8'd0;
        end
      end
      CAPTURE: begin
        if (vs_start) begin
          if (frame_idx_q < LAST_IDX) begin
            frame_idx_d = frame_idx_q + 8'd1;
          end else begin
            capture_en_d = 1'b0;
            frame_idx_d  = 8'd0;
            if (HOLDOFF_CYC == 0) begin
              state_d = IDLE;
            end else begin
              state_d = HOLDOFF;
              hold_d  = HOLD_LOAD;
            end
          end
        end
      end
      HOLDOFF: begin
        if (hold_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      trig_q          <= 1'b1;
      vs_q            <= VS_POL;
      hold_q          <= '0;
      capture_en_q    <= 1'b0;
      capture_start_q <= 1'b0;
      busy_q          <= 1'b0;
      frame_idx_q     <= 8'd0;
      trig_missed_q   <= 1'b0;
      missed_cnt_q    <= '0;
    end else begin
      state_q         <= state_d;
      trig_q          <= trig_d;
      vs_q            <= vs_d;
      hold_q          <= hold_d;
      capture_en_q    <= capture_en_d;
      capture_start_q <= capture_start_d;
      busy_q          <= busy_d;
      frame_idx_q     <= frame_idx_d;
      trig_missed_q   <= trig_missed_d;
      missed_cnt_q    <= missed_cnt_d;
    end
  end

  assign capture_en    = capture_en_q;
  assign capture_start = capture_start_q;
  assign busy          = busy_q;
  assign frame_idx     = frame_idx_q;
  assign trig_missed   = trig_missed_q;
  assign missed_cnt    = missed_cnt_q;

endmodule

// File: tb/tb_trig_frame_gate.sv
// tb/tb_trig_frame_gate.sv - scoreboard bench for trig_frame_gate
module tb_trig_frame_gate;

  localparam int NF = 2;
  localparam int HC = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b1;
  logic          trig_in = 1'b1;
  logic          vsync_in = 1'b1;
  logic          capture_en;
  logic          capture_start;
  logic          busy;
  logic [7:0]    frame_idx;
  logic          trig_missed;
  logic [CW-1:0] missed_cnt;

  trig_frame_gate #(
    .NUM_FRAMES (NF),
    .HOLDOFF_CYC(HC),
    .VS_POL     (1'b1),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .trig_in      (trig_in),
    .vsync_in     (vsync_in),
    .capture_en   (capture_en),
    .capture_start(capture_start),
    .busy         (busy),
    .frame_idx    (frame_idx),
    .trig_missed  (trig_missed),
    .missed_cnt   (missed_cnt)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int q_start[$];
  int q_end[$];
  int q_idle[$];
  int q_miss_t[$];
  int q_miss_v[$];
  int q_idx_t[$];
  int q_idx_v[$];

  // Reference: mode 0 idle, 1 waiting for vsync, 2 capturing, 3 ignoring triggers.
  bit m_tp = 1'b1;
  bit m_vp = 1'b1;
  int m_mode = 0;
  int m_frame = 0;
  int m_hold = 0;
  int m_miss = 0;
  bit en_v = 1'b1;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic pop_chk(input string name, ref int q[$]);
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got unexpected event at edge %0d expected none", name, edge_n);
    end else begin
      check(name, edge_n, q.pop_front());
    end
  endtask

  task automatic model(input bit t, input bit v, input bit e, input int tag);
    bit rise;
    bit vst;
    bit was_busy;
    rise = t && !m_tp;
    vst = v && !m_vp;
    m_tp = t;
    m_vp = v;
    was_busy = (m_mode != 0);
    if (was_busy && rise) begin
      if (m_miss < (1 << CW) - 1) m_miss++;
      q_miss_t.push_back(tag);
      q_miss_v.push_back(m_miss);
    end
    case (m_mode)
      0: if (rise && e) m_mode = 1;
      1: begin
        if (!e) m_mode = 0;
        else if (vst) begin
          m_mode = 2;
          m_frame = 0;
          q_start.push_back(tag);
        end
      end
      2: begin
        if (vst) begin
          if (m_frame < NF - 1) begin
            m_frame++;
            q_idx_t.push_back(tag);
            q_idx_v.push_back(m_frame);
          end else begin
            q_end.push_back(tag);
            m_frame = 0;
            if (HC > 0) begin
              m_mode = 3;
              m_hold = HC;
            end else m_mode = 0;
          end
        end
      end
      default: begin
        m_hold--;
        if (m_hold == 0) m_mode = 0;
      end
    endcase
    if (was_busy && m_mode == 0) q_idle.push_back(tag);
  endtask

  task automatic step(input bit t, input bit v);
    @(posedge clk);
    #1;
    trig_in = t;
    vsync_in = v;
    enable = en_v;
    model(t, v, en_v, edge_n + 1);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic trig_pulse();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // One-cycle vsync followed by gap-1 quiet cycles.
  task automatic vs_frame(input int gap);
    step(1'b0, 1'b1);
    quiet(gap - 1);
  endtask

  logic       p_busy = 1'b0;
  logic       p_cen = 1'b0;
  logic [7:0] p_idx = 8'd0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (capture_start) begin
        pop_chk("capture_start", q_start);
        check("start_frame_idx", frame_idx, 0);
        check("start_capture_en", capture_en, 1);
      end
      if (capture_en && !p_cen) check("cen_rise_has_start", capture_start, 1);
      if (!capture_en && p_cen) pop_chk("capture_end", q_end);
      if (trig_missed) begin
        pop_chk("trig_missed", q_miss_t);
        if (q_miss_v.size() > 0) check("missed_cnt", missed_cnt, q_miss_v.pop_front());
      end
      if (frame_idx != p_idx && frame_idx != 8'd0) begin
        pop_chk("frame_idx_step", q_idx_t);
        if (q_idx_v.size() > 0) check("frame_idx_val", frame_idx, q_idx_v.pop_front());
      end
      if (!busy && p_busy) pop_chk("busy_fall", q_idle);
    end
    p_busy <= busy;
    p_cen <= capture_en;
    p_idx <= frame_idx;
  end

  initial begin
    int vs_cnt;
    int vs_hi;
    repeat (3) @(posedge clk);
    #2;
    check("rst_capture_en", capture_en, 0);
    check("rst_capture_start", capture_start, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_idx", frame_idx, 0);
    check("rst_trig_missed", trig_missed, 0);
    check("rst_missed_cnt", missed_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;

    // Trigger and vsync already high at release: no edge, no capture.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    check("no_arm_at_release", busy, 0);
    quiet(5);

    // Basic capture, one reject in CAPTURE, two in HOLDOFF.
    trig_pulse();
    quiet(20);
    vs_frame(50);
    trig_pulse();
    quiet(48);
    vs_frame(100);
    step(1'b0, 1'b1);
    trig_pulse();
    trig_pulse();
    quiet(20);
    check("missed_cnt_three", missed_cnt, 3);

    // Two more rejects while armed: counter saturates.
    trig_pulse();
    trig_pulse();
    trig_pulse();
    quiet(5);
    check("missed_cnt_saturated", missed_cnt, 3);
    vs_frame(40);
    vs_frame(40);
    vs_frame(40);

    // Disarm while armed, then disable mid-capture.
    trig_pulse();
    quiet(5);
    en_v = 1'b0;
    quiet(5);
    check("disarm_idle", busy, 0);
    vs_frame(30);
    en_v = 1'b1;
    trig_pulse();
    vs_frame(30);
    en_v = 1'b0;
    vs_frame(30);
    vs_frame(30);
    quiet(10);
    en_v = 1'b1;

    // Same-cycle trigger and vsync in IDLE, then a held vsync level.
    step(1'b1, 1'b1);
    quiet(20);
    check("armed_not_started", capture_en, 0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1);
    check("held_vsync_idx", frame_idx, 0);
    quiet(10);
    vs_frame(30);
    vs_frame(30);

    // Asynchronous reset mid-capture.
    trig_pulse();
    vs_frame(15);
    mon_en = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_capture_en", capture_en, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_frame_idx", frame_idx, 0);
    q_start.delete(); q_end.delete(); q_idle.delete();
    q_miss_t.delete(); q_miss_v.delete(); q_idx_t.delete(); q_idx_v.delete();
    m_tp = 1'b1; m_vp = 1'b1; m_mode = 0; m_frame = 0; m_hold = 0; m_miss = 0;
    trig_in = 1'b0;
    vsync_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;
    quiet(3);
    trig_pulse();
    vs_frame(20);
    vs_frame(20);
    vs_frame(20);
    quiet(10);

    // Randomized traffic.
    vs_cnt = 30;
    vs_hi = 0;
    for (int i = 0; i < 4000; i++) begin
      bit t;
      bit v;
      if ($urandom_range(0, 299) == 0) en_v = ~en_v;
      t = ($urandom_range(0, 99) < 4) ? 1'b1 : trig_in & ($urandom_range(0, 1) == 1);
      if (vs_hi > 0) begin
        v = 1'b1;
        vs_hi--;
      end else if (vs_cnt == 0) begin
        v = 1'b1;
        vs_hi = $urandom_range(0, 3);
        vs_cnt = $urandom_range(15, 60);
      end else begin
        v = 1'b0;
        vs_cnt--;
      end
      step(t, v);
    end
    en_v = 1'b1;
    quiet(20);
    vs_frame(20);
    vs_frame(20);
    vs_frame(20);
    quiet(20);
    check("pending_events",
          q_start.size() + q_end.size() + q_idle.size() + q_miss_t.size() + q_idx_t.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
